// File: rtl/uart_tx_arbiter_pkg.sv
// rtl/uart_tx_arbiter_pkg.sv - shared FSM encoding and defaults for the UART TX arbiter
package uart_tx_arbiter_pkg;

    // Default bit period; must match the UART_TX serialiser being shared
    localparam int CLKS_PER_BIT_DEF = 10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_BUSY   = 2'd2,
        ST_GAP    = 2'd3
    } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// rtl/uart_tx_arbiter_rr.sv - combinational round-robin picker, first request at/after pointer
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    int            kk;
    logic [IW-1:0] k;

    // Scan requesters starting at the pointer, wrapping, and keep the first hit
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        kk      = 0;
        k       = '0;
        for (int i = 0; i < N; i++) begin
            kk = int'(ptr_i) + i;
            if (kk >= N) begin
                kk = kk - N;
            end
            k = IW'(kk);
            if (!any_o && req_i[k]) begin
                any_o      = 1'b1;
                grant_o[k] = 1'b1;
                idx_o      = k;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - shares one UART_TX serialiser among several byte producers
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int TIMEOUT_CYC  = 11 * CLKS_PER_BIT + 8
) (
    input  logic                       i_Clock,
    input  logic                       i_Reset,
    input  logic [NUM_REQ-1:0]         i_Req_Valid,
    input  logic [8*NUM_REQ-1:0]       i_Req_Byte,
    output logic [NUM_REQ-1:0]         o_Req_Ready,
    output logic [NUM_REQ-1:0]         o_Req_Done,
    output logic                       o_Tx_DV,
    output logic [7:0]                 o_Tx_Byte,
    input  logic                       i_Tx_Active,
    input  logic                       i_Tx_Done,
    output logic                       o_Busy,
    output logic [$clog2(NUM_REQ)-1:0] o_Owner,
    output logic                       o_Timeout
);

    localparam int OW = $clog2(NUM_REQ);
    localparam int WW = $clog2(TIMEOUT_CYC + 1);

    arb_state_t         state_q, state_d;
    logic [OW-1:0]      ptr_q, ptr_d;
    logic [OW-1:0]      owner_q, owner_d;
    logic [7:0]         byte_q, byte_d;
    logic [WW-1:0]      wd_q, wd_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic               timeout_q, timeout_d;

    logic [NUM_REQ-1:0] arb_grant;
    logic [OW-1:0]      arb_idx;
    logic               arb_any;
    logic [OW-1:0]      ptr_after_owner;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (OW)
    ) u_rr (
        .req_i   (i_Req_Valid),
        .ptr_i   (ptr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .any_o   (arb_any)
    );

    // Owner+1 wrapping at NUM_REQ, so a lone requester is still reached every frame
    assign ptr_after_owner = (owner_q == OW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

    // Next-state and handshake outputs; ready/DV are combinational pulses tied to the state
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        byte_d      = byte_q;
        wd_d        = wd_q;
        done_d      = '0;
        timeout_d   = 1'b0;
        o_Req_Ready = '0;
        o_Tx_DV     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Never grant while the serialiser is still finishing a frame (e.g. after reset)
                if (!i_Reset && arb_any && !i_Tx_Active) begin
                    o_Req_Ready = arb_grant;
                    byte_d      = i_Req_Byte[8*arb_idx +: 8];
                    owner_d     = arb_idx;
                    state_d     = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                o_Tx_DV = 1'b1;
                wd_d    = '0;
                state_d = ST_BUSY;
            end
            ST_BUSY: begin
                wd_d = wd_q + 1'b1;
                // Done takes priority over a watchdog expiry in the same cycle
                if (i_Tx_Done) begin
                    done_d[owner_q] = 1'b1;
                    ptr_d           = ptr_after_owner;
                    state_d         = ST_GAP;
                end else if (wd_q == WW'(TIMEOUT_CYC - 1)) begin
                    timeout_d = 1'b1;
                    ptr_d     = ptr_after_owner;
                    state_d   = ST_GAP;
                end
            end
            ST_GAP: begin
                if (!i_Tx_Active) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, pointer, latched byte/owner, watchdog and registered completion pulses
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            owner_q   <= '0;
            byte_q    <= 8'h00;
            wd_q      <= '0;
            done_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            byte_q    <= byte_d;
            wd_q      <= wd_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_Req_Done = done_q;
    assign o_Timeout  = timeout_q;
    assign o_Tx_Byte  = byte_q;
    assign o_Owner    = owner_q;
    assign o_Busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed bench for uart_tx_arbiter with a behavioural UART_TX
module tb_uart_tx_arbiter;

    localparam int CPB     = 10;
    localparam int TIMEOUT = 11 * CPB + 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_byte = '0;
    logic [3:0]  req_ready;
    logic [3:0]  req_done;
    logic        tx_dv;
    logic [7:0]  tx_byte;
    logic        busy;
    logic [1:0]  owner;
    logic        timeout;

    logic        u_act = 1'b0;
    logic        u_done = 1'b0;
    logic        u_ser = 1'b1;
    logic [9:0]  u_sh = '1;
    logic [3:0]  u_clk = '0;
    logic [3:0]  u_bit = '0;
    bit          stub_mode = 1'b0;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          dv_cyc = 0;
    logic [7:0]  rx_q[$];

    uart_tx_arbiter #(
        .NUM_REQ      (4),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .i_Clock     (clk),
        .i_Reset     (rst),
        .i_Req_Valid (req_valid),
        .i_Req_Byte  (req_byte),
        .o_Req_Ready (req_ready),
        .o_Req_Done  (req_done),
        .o_Tx_DV     (tx_dv),
        .o_Tx_Byte   (tx_byte),
        .i_Tx_Active (u_act),
        .i_Tx_Done   (u_done),
        .o_Busy      (busy),
        .o_Owner     (owner),
        .o_Timeout   (timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural UART_TX: start bit, 8 data bits LSB first, stop bit, then done (unless stubbed)
    always @(posedge clk) begin
        u_done <= 1'b0;
        if (!u_act) begin
            if (tx_dv) begin
                u_act <= 1'b1;
                u_sh  <= {1'b1, tx_byte, 1'b0};
                u_ser <= 1'b0;
                u_clk <= '0;
                u_bit <= '0;
            end
        end else if (u_clk != 4'(CPB - 1)) begin
            u_clk <= u_clk + 1'b1;
        end else begin
            u_clk <= '0;
            if (u_bit == 4'd9) begin
                u_act  <= 1'b0;
                u_ser  <= 1'b1;
                u_done <= !stub_mode;
            end else begin
                u_bit <= u_bit + 1'b1;
                u_sh  <= {1'b1, u_sh[9:1]};
                u_ser <= u_sh[1];
            end
        end
    end

    // Serial line decoder: mid-bit sampling from the start-bit falling edge
    always begin
        logic [7:0] b;
        @(negedge u_ser);
        repeat (CPB / 2) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(posedge clk);
            b[i] = u_ser;
        end
        repeat (CPB) @(posedge clk);
        rx_q.push_back(b);
    end

    initial begin
        #500000;
        $display("FAIL global_timeout observed=hang expected=finish");
        $fatal(1, "simulation did not terminate");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] b);
        logic [7:0] got;
        got = 'x;
        if (rx_q.size() > 0) got = rx_q.pop_front();
        chk({tag, " serial_byte"}, {24'h0, got}, {24'h0, b});
    endtask

    task automatic grant(input int idx, input logic [7:0] b, input bit drop, input string tag);
        int n;
        n = 0;
        while (req_ready == 4'b0 && n < 400) begin
            step();
            n++;
        end
        chk({tag, " ready"}, {28'h0, req_ready}, 32'(4'b1 << idx));
        step();
        if (drop) req_valid[idx] = 1'b0;
        #1;
        dv_cyc = cyc;
        chk({tag, " dv"}, {31'h0, tx_dv}, 32'd1);
        chk({tag, " tx_byte"}, {24'h0, tx_byte}, {24'h0, b});
        chk({tag, " owner"}, {30'h0, owner}, 32'(idx));
        chk({tag, " ready_off"}, {28'h0, req_ready}, 32'd0);
        chk({tag, " no_done_at_dv"}, {28'h0, req_done}, 32'd0);
        step();
        chk({tag, " dv_pulse"}, {31'h0, tx_dv}, 32'd0);
        chk({tag, " busy"}, {31'h0, busy}, 32'd1);
    endtask

    task automatic finish_frame(input int idx, input logic [7:0] b, input string tag);
        int n;
        bit to_seen;
        n = 0;
        to_seen = 1'b0;
        while (req_done == 4'b0 && n < 300) begin
            if (timeout) to_seen = 1'b1;
            step();
            n++;
        end
        chk({tag, " req_done"}, {28'h0, req_done}, 32'(4'b1 << idx));
        chk({tag, " no_timeout"}, {31'h0, to_seen}, 32'd0);
        chk({tag, " tx_byte_held"}, {24'h0, tx_byte}, {24'h0, b});
        step();
        chk({tag, " done_pulse"}, {28'h0, req_done}, 32'd0);
        pop_chk(tag, b);
    endtask

    initial begin
        int  n;
        bit  flag;
        bit  done_flag;

        // Reset state
        step();
        chk("rst ready", {28'h0, req_ready}, 32'd0);
        chk("rst done", {28'h0, req_done}, 32'd0);
        chk("rst dv", {31'h0, tx_dv}, 32'd0);
        chk("rst tx_byte", {24'h0, tx_byte}, 32'd0);
        chk("rst busy", {31'h0, busy}, 32'd0);
        chk("rst owner", {30'h0, owner}, 32'd0);
        chk("rst timeout", {31'h0, timeout}, 32'd0);
        rst = 1'b0;
        step();

        // 1: single requester from idle
        req_valid[0] = 1'b1;
        req_byte[7:0] = 8'hA5;
        #1;
        grant(0, 8'hA5, 1'b1, "t1");
        finish_frame(0, 8'hA5, "t1");
        chk("t1 owner_idle", {30'h0, owner}, 32'd0);

        // 2: all four together from pointer 0
        rst = 1'b1;
        step();
        rst = 1'b0;
        req_byte = 32'h44332211;
        req_valid = 4'b1111;
        #1;
        for (int r = 0; r < 4; r++) begin
            grant(r, 8'(8'h11 * (r + 1)), 1'b1, $sformatf("t2_%0d", r));
            finish_frame(r, 8'(8'h11 * (r + 1)), $sformatf("t2_%0d", r));
        end

        // 3: req2 held, req1 raised mid-frame -> 2,1,2
        req_byte[23:16] = 8'h5C;
        req_valid[2] = 1'b1;
        #1;
        grant(2, 8'h5C, 1'b0, "t3a");
        req_byte[15:8] = 8'h3E;
        req_valid[1] = 1'b1;
        finish_frame(2, 8'h5C, "t3a");
        grant(1, 8'h3E, 1'b1, "t3b");
        finish_frame(1, 8'h3E, "t3b");
        grant(2, 8'h5C, 1'b1, "t3c");
        finish_frame(2, 8'h5C, "t3c");

        // 4: UART never reports done -> watchdog abort, then next requester served
        stub_mode = 1'b1;
        req_byte[7:0] = 8'h77;
        req_byte[15:8] = 8'h88;
        req_valid[0] = 1'b1;
        req_valid[1] = 1'b1;
        #1;
        grant(0, 8'h77, 1'b1, "t4a");
        n = 0;
        done_flag = 1'b0;
        while (!timeout && n < 400) begin
            if (req_done != 4'b0) done_flag = 1'b1;
            step();
            n++;
        end
        chk("t4 timeout", {31'h0, timeout}, 32'd1);
        chk("t4 timeout_latency", 32'(cyc - dv_cyc), 32'(TIMEOUT + 1));
        chk("t4 no_req_done", {31'h0, done_flag}, 32'd0);
        step();
        chk("t4 timeout_pulse", {31'h0, timeout}, 32'd0);
        pop_chk("t4a", 8'h77);
        stub_mode = 1'b0;
        grant(1, 8'h88, 1'b1, "t4b");
        finish_frame(1, 8'h88, "t4b");

        // 5: reset mid-frame, no grant until the UART goes inactive, then pointer 0
        req_byte[23:16] = 8'h3C;
        req_valid[2] = 1'b1;
        #1;
        grant(2, 8'h3C, 1'b1, "t5a");
        req_byte[7:0] = 8'h96;
        req_valid[0] = 1'b1;
        repeat (30) step();
        rst = 1'b1;
        #1;
        chk("t5 rst_busy", {31'h0, busy}, 32'd0);
        chk("t5 rst_owner", {30'h0, owner}, 32'd0);
        chk("t5 rst_tx_byte", {24'h0, tx_byte}, 32'd0);
        chk("t5 rst_ready", {28'h0, req_ready}, 32'd0);
        step();
        step();
        rst = 1'b0;
        #1;
        n = 0;
        flag = 1'b0;
        while (u_act && n < 300) begin
            if (req_ready != 4'b0 || tx_dv) flag = 1'b1;
            step();
            n++;
        end
        chk("t5 no_grant_while_active", {31'h0, flag}, 32'd0);
        pop_chk("t5a", 8'h3C);
        grant(0, 8'h96, 1'b1, "t5b");
        finish_frame(0, 8'h96, "t5b");

        // 6: one-cycle valid pulse while busy is never granted
        req_byte[15:8] = 8'h5A;
        req_valid[1] = 1'b1;
        #1;
        grant(1, 8'h5A, 1'b1, "t6");
        repeat (10) step();
        req_byte[31:24] = 8'hE7;
        req_valid[3] = 1'b1;
        step();
        req_valid[3] = 1'b0;
        finish_frame(1, 8'h5A, "t6");
        flag = 1'b0;
        repeat (20) begin
            if (req_ready != 4'b0 || tx_dv) flag = 1'b1;
            step();
        end
        chk("t6 no_spurious_grant", {31'h0, flag}, 32'd0);
        chk("t6 idle", {31'h0, busy}, 32'd0);
        chk("t6 owner_held", {30'h0, owner}, 32'd1);
        chk("t6 no_extra_frame", 32'(rx_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
